// File: rtl/irq_ctl.sv
// irq_ctl: interrupt front-end for the 65C02 control unit.
// Combines NIRQ maskable, level-sensitive IRQ lines and one rising-edge NMI
// into a single latched request with a 16-bit vector. Requests are sampled
// only at instruction boundaries (sync) and held until ctl acknowledges.
//
// State table:
//   state | meaning
//   IDLE  | no request presented; sample at sync when RDY=1
//   REQ   | take=1, vec/src/nmi_take latched until ack with RDY=1
//
// Ports:
//   clk       CPU clock
//   RST       asynchronous active-low reset
//   RDY       CPU ready; 0 freezes the request state machine
//   sync      start-of-instruction strobe
//   I         interrupt-disable flag
//   IRQ       level-sensitive requests, active high
//   NMI       non-maskable request, rising edge
//   mask_we   mask write strobe
//   mask_di   mask write data (1 = masked)
//   ack       vector fetched; ends the request
//   take      request to ctl
//   nmi_take  current request is NMI
//   vec       vector address of current request
//   src       IRQ source index of current request
//   pending   synchronised IRQ & ~mask
//   mask_do   current mask register
module irq_ctl #(
  parameter int              NIRQ        = 8,
  parameter int              SYNC_STAGES = 2,
  parameter int              VECTORED    = 1,
  parameter logic [15:0]     VEC_BASE    = 16'hFFE0,
  parameter logic [15:0]     NMI_VEC     = 16'hFFFA,
  parameter logic [NIRQ-1:0] MASK_RST    = '1,
  localparam int             SW          = (NIRQ > 1) ? $clog2(NIRQ) : 1
) (
  input  logic            clk,
  input  logic            RST,
  input  logic            RDY,
  input  logic            sync,
  input  logic            I,
  input  logic [NIRQ-1:0] IRQ,
  input  logic            NMI,
  input  logic            mask_we,
  input  logic [NIRQ-1:0] mask_di,
  input  logic            ack,
  output logic            take,
  output logic            nmi_take,
  output logic [15:0]     vec,
  output logic [SW-1:0]   src,
  output logic [NIRQ-1:0] pending,
  output logic [NIRQ-1:0] mask_do
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t          state_q, state_d;
  logic            nmi_take_q, nmi_take_d;
  logic [15:0]     vec_q, vec_d;
  logic [SW-1:0]   src_q, src_d;
  logic            nmi_pend_q, nmi_pend_d;
  logic            nmi_prev_q;
  logic [NIRQ-1:0] mask_q;

  logic [NIRQ-1:0] irq_s;
  logic            nmi_s;
  logic            nmi_edge;
  logic [NIRQ-1:0] active;
  logic [SW-1:0]   winner;
  logic [15:0]     win16;
  logic [15:0]     irq_vec;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign irq_s = IRQ;
      assign nmi_s = NMI;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0][NIRQ-1:0] irq_sync_q;
      logic [SYNC_STAGES-1:0]           nmi_sync_q;
      always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
          irq_sync_q <= '0;
          nmi_sync_q <= '0;
        end else begin
          irq_sync_q[0] <= IRQ;
          nmi_sync_q[0] <= NMI;
          for (int k = 1; k < SYNC_STAGES; k++) begin
            irq_sync_q[k] <= irq_sync_q[k-1];
            nmi_sync_q[k] <= nmi_sync_q[k-1];
          end
        end
      end
      assign irq_s = irq_sync_q[SYNC_STAGES-1];
      assign nmi_s = nmi_sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign nmi_edge = nmi_s & ~nmi_prev_q;
  assign pending  = irq_s & ~mask_q;
  assign active   = pending & ~{NIRQ{I}};

  // Lowest index wins: scan downwards so the last hit is the smallest.
  always_comb begin
    winner = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (active[i]) winner = SW'(i);
    end
  end

  assign win16   = 16'(winner);
  assign irq_vec = (VECTORED != 0) ? (VEC_BASE + (win16 << 1)) : 16'hFFFE;

  always_comb begin
    state_d    = state_q;
    nmi_take_d = nmi_take_q;
    vec_d      = vec_q;
    src_d      = src_q;
    nmi_pend_d = nmi_pend_q;
    if (RDY) begin
      case (state_q)
        IDLE: begin
          if (sync && (nmi_pend_q || (active != '0))) begin
            state_d = REQ;
            if (nmi_pend_q) begin
              nmi_take_d = 1'b1;
              vec_d      = NMI_VEC;
            end else begin
              nmi_take_d = 1'b0;
              src_d      = winner;
              vec_d      = irq_vec;
            end
          end
        end
        REQ: begin
          if (ack) begin
            state_d    = IDLE;
            nmi_take_d = 1'b0;
            if (nmi_take_q) nmi_pend_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // A fresh edge outranks the clear on ack so it is never lost.
    if (nmi_edge) nmi_pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      nmi_take_q <= 1'b0;
      vec_q      <= '0;
      src_q      <= '0;
      nmi_pend_q <= 1'b0;
      nmi_prev_q <= 1'b0;
      mask_q     <= MASK_RST;
    end else begin
      state_q    <= state_d;
      nmi_take_q <= nmi_take_d;
      vec_q      <= vec_d;
      src_q      <= src_d;
      nmi_pend_q <= nmi_pend_d;
      nmi_prev_q <= nmi_s;
      if (mask_we) mask_q <= mask_di;
    end
  end

  assign take     = (state_q == REQ);
  assign nmi_take = nmi_take_q;
  assign vec      = vec_q;
  assign src      = src_q;
  assign mask_do  = mask_q;

endmodule
